ig_scan_ctrl: RTL and testbench
===============================

IG_SCAN_CTRL -- requirements
Module: ig_scan_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have: reset  in  1  asynchronous, active-high.
REQ-003 SHALL have: start  in  1  one-cycle request to process one frame.
REQ-004 SHALL have: busy  out  1  high while frame in progress; done  out  1  frame complete, held until next accepted start.
REQ-005 SHALL have: img_rd  out  1; img_wr  out  1 (tied 0); img_addr  out  16; img_do  out  8 (tied 0); img_di  in  8  pixel read data.
REQ-006 SHALL have: grad_wr  out  1; grad_rd  out  1 (tied 0); grad_addr  out  16; grad_do  out  20  {gx[9:0],gy[9:0]}; grad_di  in  20 (unused).
REQ-007 SHALL have: grad_ready  in  1  gradient memory accepts write (used only when IG_STALL_EN defined).

Function
REQ-008 Image SHALL be 256x256, 8-bit, addr = row*256+col; img_di valid in the same cycle img_rd/img_addr are driven, sampled on the closing rising edge.
REQ-009 SHALL compute gradients for rows 0..254, cols 0..254 (65025 pixels), raster order; no other grad address is written.
REQ-010 Per pixel (r,c): A=img(r,c), R=img(r,c+1), D=img(r+1,c); gx=R-A, gy=D-A, each 10-bit two's complement of zero-extended operands.
REQ-011 FSM states SHALL be IDLE, LOAD_A, LOAD_R, LOAD_D, WRITE, DONE.
REQ-012 IDLE/DONE: start=1 -> LOAD_A with r=0,c=0; done cleared, busy set on the same edge.
REQ-013 LOAD_A: img_rd=1, img_addr=r*256+c, capture A -> LOAD_R.
REQ-014 LOAD_R: img_rd=1, img_addr=r*256+c+1, capture R -> LOAD_D.
REQ-015 LOAD_D: img_rd=1, img_addr=(r+1)*256+c, capture D -> WRITE.
REQ-016 WRITE: grad_wr=1, grad_addr=r*256+c, grad_do per REQ-010; write completes this cycle (or per REQ-026).
REQ-017 On WRITE completion: c<254 -> A<=R, c<=c+1, LOAD_R; c=254 and r<254 -> c<=0, r<=r+1, LOAD_A; c=254 and r=254 -> DONE.
REQ-018 Cycles per row SHALL be 4+254*3=766; frame SHALL take 195330 cycles from first LOAD_A to DONE entry without stalls.
REQ-019 DONE: busy=0, done=1, no memory strobes.
REQ-020 start while busy SHALL be ignored.
REQ-021 Outputs img_rd, img_addr, grad_wr, grad_addr, grad_do SHALL be decoded from current state/registers (no added latency); when the strobe is low, the address SHALL be 0, img_rd/grad_wr 0 outside listed states.
REQ-022 Exactly one of img_rd, grad_wr SHALL be high in any cycle while busy.

Reset
REQ-023 reset=1 SHALL force IDLE immediately, regardless of clock, including mid-frame.
REQ-024 Reset values: busy=0, done=0, img_rd=0, img_addr=0, grad_wr=0, grad_addr=0, grad_do=0, r=c=0, A=R=D=0.
REQ-025 After reset mid-frame, next start SHALL restart at pixel (0,0); no partial resume.

Configuration
REQ-026 IG_STALL_EN defined: WRITE completes only on a cycle with grad_ready=1; until then grad_wr, grad_addr, grad_do held stable.
REQ-027 IG_STALL_EN undefined: grad_ready ignored; WRITE always lasts exactly one cycle.

Verification
REQ-028 Reset asserted asynchronously between clocks -> all outputs 0 before next rising edge; busy=0, done=0.
REQ-029 Ramp image img[a]=a[7:0], start -> first write grad_addr=0x0000, grad_do=0x00400; 65025 writes; last grad_addr=0xFEFE; done 195330 cycles after first LOAD_A.
REQ-030 Constant image 0x80 -> every grad_do=0x00000, no write to col 255 or row 255.
REQ-031 img(0,0)=0xFF, img(0,1)=0x00, img(1,0)=0x00 -> first grad_do=0xC0701.
REQ-032 IG_STALL_EN, grad_ready low 5 cycles at first WRITE -> grad_wr high 6 cycles, stable addr/data, exactly one write counted, frame length +5.
REQ-033 Reset pulse at 1000th write, then start -> first read img_addr=0x0000, full 65025-write frame, done=1.

Source files
------------

// File: rtl/ig_scan_ctrl.sv
// ig_scan_ctrl: raster scan of a 256x256 8-bit image producing forward-difference
// gradients {gx,gy} for every pixel that has a right and a lower neighbour.
// Optional feature: define IG_STALL_EN to make the gradient write wait for grad_ready.
// LAST_IDX is the last row/column scanned (254 for the full image); addresses always
// use the 256-wide row pitch, so smaller values simply scan a top-left sub-window.
module ig_scan_ctrl #(
    parameter logic [7:0] LAST_IDX = 8'd254
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        img_rd,
    output logic        img_wr,
    output logic [15:0] img_addr,
    output logic [7:0]  img_do,
    input  logic [7:0]  img_di,
    output logic        grad_wr,
    output logic        grad_rd,
    output logic [15:0] grad_addr,
    output logic [19:0] grad_do,
    input  logic [19:0] grad_di,
    input  logic        grad_ready
);

    typedef enum logic [2:0] {
        IDLE, LOAD_A, LOAD_R, LOAD_D, WRITE, DONE
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] r_q, r_d, c_q, c_d;
    logic [7:0] a_q, a_d, rr_q, rr_d, d_q, d_d;
    logic       wr_fire;
    logic [9:0] gx, gy;
    logic       unused_ok;

    // Gradient memory handshake: with stalls enabled the write retires only when accepted.
`ifdef IG_STALL_EN
    assign wr_fire   = grad_ready;
    assign unused_ok = ^grad_di;
`else
    assign wr_fire   = 1'b1;
    assign unused_ok = ^{grad_di, grad_ready};
`endif

    // The controller never writes the image or reads back gradients.
    assign img_wr  = 1'b0;
    assign img_do  = 8'h00;
    assign grad_rd = 1'b0;

    // Zero-extended operands so 255-0 and 0-255 both fit in 10-bit two's complement.
    assign gx = {2'b00, rr_q} - {2'b00, a_q};
    assign gy = {2'b00, d_q}  - {2'b00, a_q};

    assign busy = (state_q == LOAD_A) || (state_q == LOAD_R) ||
                  (state_q == LOAD_D) || (state_q == WRITE);
    assign done = (state_q == DONE);

    // State, scan position and captured pixel registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            r_q     <= 8'd0;
            c_q     <= 8'd0;
            a_q     <= 8'd0;
            rr_q    <= 8'd0;
            d_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
            a_q     <= a_d;
            rr_q    <= rr_d;
            d_q     <= d_d;
        end
    end

    // Next-state and memory strobes decoded straight from the current state.
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        c_d       = c_q;
        a_d       = a_q;
        rr_d      = rr_q;
        d_d       = d_q;
        img_rd    = 1'b0;
        img_addr  = 16'h0000;
        grad_wr   = 1'b0;
        grad_addr = 16'h0000;
        grad_do   = 20'h00000;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD_A;
                    r_d     = 8'd0;
                    c_d     = 8'd0;
                end
            end
            LOAD_A: begin
                img_rd   = 1'b1;
                img_addr = {r_q, c_q};
                a_d      = img_di;
                state_d  = LOAD_R;
            end
            LOAD_R: begin
                img_rd   = 1'b1;
                img_addr = {r_q, c_q + 8'd1};
                rr_d     = img_di;
                state_d  = LOAD_D;
            end
            LOAD_D: begin
                img_rd   = 1'b1;
                img_addr = {r_q + 8'd1, c_q};
                d_d      = img_di;
                state_d  = WRITE;
            end
            WRITE: begin
                grad_wr   = 1'b1;
                grad_addr = {r_q, c_q};
                grad_do   = {gx, gy};
                if (wr_fire) begin
                    if (c_q != LAST_IDX) begin
                        // Slide right: this pixel's right neighbour is the next pixel's A.
                        a_d     = rr_q;
                        c_d     = c_q + 8'd1;
                        state_d = LOAD_R;
                    end else if (r_q != LAST_IDX) begin
                        c_d     = 8'd0;
                        r_d     = r_q + 8'd1;
                        state_d = LOAD_A;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ig_scan_ctrl.sv
// Bench for ig_scan_ctrl: a scan-sub-window build (LAST_IDX=20) keeps frames short.
// The reference is the ordered list of memory accesses a frame must make.
module tb_ig_scan_ctrl;

    localparam logic [7:0] LAST = 8'd20;
    localparam int N = int'(LAST) + 1;
    localparam int FRAME_CYC = N * (4 + 3 * int'(LAST));

    logic        clk = 1'b0;
    logic        reset, start, grad_ready;
    logic        busy, done, img_rd, img_wr, grad_wr, grad_rd;
    logic [15:0] img_addr, grad_addr;
    logic [7:0]  img_do, img_di;
    logic [19:0] grad_do, grad_di;

    logic [7:0]  mem [0:65535];

    typedef struct {
        bit          wr;
        logic [15:0] addr;
        logic [19:0] data;
    } ev_t;
    ev_t exp_q[$];

    int total = 0, bad = 0;
    bit chk_en = 1'b0;
    bit rand_rdy = 1'b0;
    int busy_cyc, stall_cyc, nwr, nrd;
    logic [19:0] first_do;
    logic [15:0] first_rd, last_waddr;

    ig_scan_ctrl #(.LAST_IDX(LAST)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .img_rd(img_rd), .img_wr(img_wr), .img_addr(img_addr), .img_do(img_do),
        .img_di(img_di), .grad_wr(grad_wr), .grad_rd(grad_rd), .grad_addr(grad_addr),
        .grad_do(grad_do), .grad_di(grad_di), .grad_ready(grad_ready)
    );

    always #5 clk = ~clk;
    assign img_di  = mem[img_addr];
    assign grad_di = 20'hABCDE;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Expected access list: for each pixel its three reads (A only at row start), then the write.
    task automatic build_expect();
        exp_q.delete();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                int a, rt, dn;
                logic [9:0] gx, gy;
                a  = mem[r*256 + c];
                rt = mem[r*256 + c + 1];
                dn = mem[(r+1)*256 + c];
                if (c == 0) exp_q.push_back('{1'b0, 16'(r*256 + c), 20'h0});
                exp_q.push_back('{1'b0, 16'(r*256 + c + 1), 20'h0});
                exp_q.push_back('{1'b0, 16'((r+1)*256 + c), 20'h0});
                gx = 10'(rt - a);
                gy = 10'(dn - a);
                exp_q.push_back('{1'b1, 16'(r*256 + c), {gx, gy}});
            end
    endtask

    // Ready driver: random back-pressure when enabled, always ready otherwise.
    initial begin
        grad_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            grad_ready = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Every cycle: compare strobes, addresses and data against the head of the access list.
    always @(negedge clk) begin
        if (chk_en && !reset) begin
            chk("tied_low", {img_wr, grad_rd, 8'(img_do)}, 0);
            if (busy) begin
                busy_cyc++;
                chk("one_strobe", int'(img_rd) + int'(grad_wr), 1);
                if (img_rd) begin
                    if (exp_q.size() == 0 || exp_q[0].wr) chk("rd_order", 1, 0);
                    else begin
                        chk("rd_addr", img_addr, exp_q[0].addr);
                        if (nrd == 0) first_rd = img_addr;
                        nrd++;
                        void'(exp_q.pop_front());
                    end
                end
                if (grad_wr) begin
                    if (exp_q.size() == 0 || !exp_q[0].wr) chk("wr_order", 1, 0);
                    else begin
                        bit acc;
                        chk("wr_addr", grad_addr, exp_q[0].addr);
                        chk("wr_data", grad_do, exp_q[0].data);
`ifdef IG_STALL_EN
                        acc = grad_ready;
`else
                        acc = 1'b1;
`endif
                        if (acc) begin
                            if (nwr == 0) first_do = grad_do;
                            last_waddr = grad_addr;
                            nwr++;
                            void'(exp_q.pop_front());
                        end else stall_cyc++;
                    end
                end
            end else begin
                chk("idle_strobe", {img_rd, grad_wr}, 0);
                chk("idle_bus", {img_addr, 16'(grad_addr | grad_do[15:0])}, 0);
            end
        end
    end

    task automatic fill(input int pat);
        for (int a = 0; a < 65536; a++)
            case (pat)
                0: mem[a] = 8'(a);
                1: mem[a] = 8'h80;
                default: mem[a] = 8'($urandom);
            endcase
        if (pat == 2) begin
            mem[0] = 8'hFF; mem[1] = 8'h00; mem[256] = 8'h00;
        end
    endtask

    task automatic kick();
        busy_cyc = 0; stall_cyc = 0; nwr = 0; nrd = 0;
        chk_en = 1'b1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        #3;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
    endtask

    task automatic run_frame(input int pat, input bit pin, input logic [19:0] first_exp);
        int i;
        fill(pat);
        build_expect();
        kick();
        // A start pulse mid-frame must not disturb the scan.
        repeat (40) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (i = 0; i < 40 * FRAME_CYC && !done; i++) @(posedge clk);
        if (!done) chk("frame_timeout", 0, 1);
        #4;
        chk("done_state", {busy, done}, 2'b01);
        chk("write_count", nwr, N * N);
        chk("reads_count", nrd, N * (2 * N + 1));
        chk("frame_len", busy_cyc, FRAME_CYC + stall_cyc);
        chk("exp_left", exp_q.size(), 0);
        chk("first_rd", first_rd, 16'h0000);
        chk("last_waddr", last_waddr, 16'h1414);
        if (pin) chk("first_do", first_do, first_exp);
        if (stall_cyc == 0) chk("frame_len_lit", busy_cyc, 1344);
        repeat (3) @(posedge clk);
        #4 chk("done_held", done, 1);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        #1;
        chk("rst_outs", {busy, done, img_rd, grad_wr}, 0);
        chk("rst_bus", {img_addr, 16'(grad_addr | grad_do[15:0])}, 0);
        chk("rst_do_hi", 32'(grad_do[19:16]), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;

        run_frame(0, 1'b1, 20'h00400);
        run_frame(1, 1'b1, 20'h00000);
        run_frame(2, 1'b1, 20'hC0701);
        run_frame(3, 1'b0, 20'h0);
        rand_rdy = 1'b1;
        run_frame(3, 1'b0, 20'h0);
        run_frame(2, 1'b1, 20'hC0701);
        rand_rdy = 1'b0;

        // Asynchronous reset part-way through a frame, then a clean restart.
        fill(3);
        build_expect();
        kick();
        for (int i = 0; i < 5000 && nwr < 37; i++) @(posedge clk);
        chk("reached_37", nwr, 37);
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("async_rst_outs", {busy, done, img_rd, grad_wr}, 0);
        chk("async_rst_bus", {img_addr, grad_addr}, 0);
        chk("async_rst_do", grad_do, 0);
        @(posedge clk); #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #4 chk("post_rst_idle", {busy, done}, 0);
        run_frame(0, 1'b1, 20'h00400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
